// File: rtl/count_sequencer_ctrl.sv
// Run controller for a WIDTH-bit counter datapath.
// Sequences clear, zero check, count-to-target and done, with watchdog.
module count_sequencer_ctrl #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [7:0]       run_cnt
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_CLR,
        RUN,
        DONE,
        ERR
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] target_r, target_nx;
    logic [WIDTH-1:0] prev_q;
    logic [WDW-1:0]   wd, wd_nx, wd_inc;
    logic             wd_hit;
    logic [7:0]       run_cnt_nx;

    assign wd_inc = wd + WDW'(1);
    assign wd_hit = (wd_inc == WDW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            target_r <= '0;
            prev_q   <= '0;
            wd       <= '0;
            run_cnt  <= '0;
        end else begin
            state    <= state_nx;
            target_r <= target_nx;
            prev_q   <= cnt_q;
            wd       <= wd_nx;
            run_cnt  <= run_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        target_nx  = target_r;
        wd_nx      = wd;
        run_cnt_nx = run_cnt;
        unique case (state)
            IDLE, ERR: begin
                if (start) begin
                    state_nx   = CLEAR;
                    target_nx  = target;
                    run_cnt_nx = '0;
                    wd_nx      = '0;
                end
            end
            CLEAR: begin
                state_nx = WAIT_CLR;
                wd_nx    = '0;
            end
            WAIT_CLR: begin
                if (cnt_q == '0) begin
                    state_nx = RUN;
                    wd_nx    = '0;
                end else begin
                    wd_nx = wd_inc;
                    if (wd_hit) state_nx = ERR;
                end
            end
            RUN: begin
                if (cnt_q == target_r) begin
                    state_nx = DONE;
                end else if (cnt_q != prev_q) begin
                    wd_nx = '0;
                end else begin
                    wd_nx = wd_inc;
                    if (wd_hit) state_nx = ERR;
                end
            end
            DONE: begin
                if (run_cnt != 8'hFF) run_cnt_nx = run_cnt + 8'd1;
                state_nx = auto_reload ? CLEAR : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Abort wins over every other transition but keeps the DONE count
        if (stop && (state inside {CLEAR, WAIT_CLR, RUN, DONE}))
            state_nx = IDLE;
    end

    assign cnt_clr     = (state == CLEAR);
    assign cnt_en      = (state == RUN) && (cnt_q != target_r);
    assign ready       = (state == IDLE) || (state == ERR);
    assign busy        = !ready;
    assign done        = (state == DONE);
    assign timeout_err = (state == ERR);

endmodule
